// File: rtl/learn_guide.sv
// Learning-mode guide: walks a song ROM, lights the key/pitch to play, debounces and grades presses.
// Optional build macro LEARN_RETRY_EN: a wrong press repeats the same note instead of advancing.
module learn_guide #(
  parameter int ADDR_W          = 6,
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mode,
  input  logic [6:0]        key,
  input  logic [1:0]        pitch,
  output logic [ADDR_W-1:0] song_addr,
  input  logic [4:0]        song_note,
  output logic [6:0]        led,
  output logic [1:0]        pitch_led,
  output logic [7:0]        hits,
  output logic [7:0]        misses,
  output logic              done
);

  // The counter only needs to reach DEBOUNCE_CYCLES-1: the final stable cycle triggers the move.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_SHOW      = 3'd3,
    ST_PRESS     = 3'd4,
    ST_RELEASE   = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  // Note index 1..21 back to {pitch setting, one-hot key}; anything else decodes to all zeros.
  function automatic logic [8:0] decode_note(input logic [4:0] n);
    logic [8:0] r;
    r = 9'd0;
    if (n >= 5'd1 && n <= 5'd7) begin
      r = {2'b01, 7'(7'd1 << (n - 5'd1))};
    end else if (n >= 5'd8 && n <= 5'd14) begin
      r = {2'b00, 7'(7'd1 << (n - 5'd8))};
    end else if (n >= 5'd15 && n <= 5'd21) begin
      r = {2'b10, 7'(7'd1 << (n - 5'd15))};
    end else begin
      r = 9'd0;
    end
    return r;
  endfunction

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [6:0]        led_r, led_s;
  logic [1:0]        pled_r, pled_s;
  logic [7:0]        hits_r, hits_s;
  logic [7:0]        misses_r, misses_s;
  logic              done_r, done_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [8:0]        prev_r;
  logic [8:0]        latch_r, latch_s;
  logic              match_r, match_s;
  logic [4:0]        target_r, target_s;

  logic              learn_s;
  logic [8:0]        cur_s;
  logic [8:0]        note_dec_s;
  logic [8:0]        tgt_dec_s;
  logic              retry_s;

  assign learn_s    = (mode == 3'b111);
  assign cur_s      = {pitch, key};
  assign note_dec_s = decode_note(song_note);
  assign tgt_dec_s  = decode_note(target_r);

`ifdef LEARN_RETRY_EN
  assign retry_s = ~match_r;
`else
  assign retry_s = 1'b0;
`endif

  // Next-state and next-register computation for the whole guide.
  always_comb begin
    state_s  = state_r;
    addr_s   = addr_r;
    led_s    = led_r;
    pled_s   = pled_r;
    hits_s   = hits_r;
    misses_s = misses_r;
    done_s   = done_r;
    cnt_s    = cnt_r;
    latch_s  = latch_r;
    match_s  = match_r;
    target_s = target_r;

    if (!learn_s) begin
      state_s = ST_IDLE;
      addr_s  = '0;
      led_s   = 7'd0;
      pled_s  = 2'b00;
      done_s  = 1'b0;
      cnt_s   = '0;
      match_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          hits_s   = 8'd0;
          misses_s = 8'd0;
          addr_s   = '0;
          led_s    = 7'd0;
          pled_s   = 2'b00;
          done_s   = 1'b0;
          cnt_s    = '0;
          state_s  = ST_FETCH;
        end
        ST_FETCH: begin
          state_s = ST_WAIT_DATA;
        end
        ST_WAIT_DATA: begin
          target_s = song_note;
          cnt_s    = '0;
          if (song_note == 5'd0 || song_note > 5'd21) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
            led_s   = 7'd0;
            pled_s  = 2'b00;
          end else begin
            state_s = ST_SHOW;
            pled_s  = note_dec_s[8:7];
            led_s   = note_dec_s[6:0];
          end
        end
        ST_SHOW: begin
          pled_s = tgt_dec_s[8:7];
          led_s  = tgt_dec_s[6:0];
          // Pitch is part of the compared value, so a pitch change restarts the count too.
          if (key != 7'd0 && cur_s == prev_r) begin
            if (cnt_r == CNT_LAST) begin
              latch_s = cur_s;
              cnt_s   = '0;
              state_s = ST_PRESS;
            end else begin
              cnt_s = cnt_r + CNT_ONE;
            end
          end else begin
            cnt_s = '0;
          end
        end
        ST_PRESS: begin
          cnt_s   = '0;
          state_s = ST_RELEASE;
          if (latch_r == {pled_r, led_r}) begin
            match_s = 1'b1;
            hits_s  = (hits_r == 8'hFF) ? hits_r : hits_r + 8'd1;
          end else begin
            match_s  = 1'b0;
            misses_s = (misses_r == 8'hFF) ? misses_r : misses_r + 8'd1;
          end
        end
        ST_RELEASE: begin
          if (key == 7'd0) begin
            if (cnt_r == CNT_LAST) begin
              cnt_s = '0;
              if (retry_s) begin
                state_s = ST_SHOW;
              end else if (&addr_r) begin
                state_s = ST_DONE;
                done_s  = 1'b1;
                led_s   = 7'd0;
                pled_s  = 2'b00;
              end else begin
                addr_s  = addr_r + ADDR_ONE;
                state_s = ST_FETCH;
              end
            end else begin
              cnt_s = cnt_r + CNT_ONE;
            end
          end else begin
            cnt_s = '0;
          end
        end
        ST_DONE: begin
          done_s = 1'b1;
          led_s  = 7'd0;
          pled_s = 2'b00;
        end
        default: begin
          state_s = ST_IDLE;
          addr_s  = '0;
          led_s   = 7'd0;
          pled_s  = 2'b00;
          done_s  = 1'b0;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      addr_r   <= '0;
      led_r    <= 7'd0;
      pled_r   <= 2'b00;
      hits_r   <= 8'd0;
      misses_r <= 8'd0;
      done_r   <= 1'b0;
      cnt_r    <= '0;
      prev_r   <= 9'd0;
      latch_r  <= 9'd0;
      match_r  <= 1'b0;
      target_r <= 5'd0;
    end else begin
      state_r  <= state_s;
      addr_r   <= addr_s;
      led_r    <= led_s;
      pled_r   <= pled_s;
      hits_r   <= hits_s;
      misses_r <= misses_s;
      done_r   <= done_s;
      cnt_r    <= cnt_s;
      prev_r   <= cur_s;
      latch_r  <= latch_s;
      match_r  <= match_s;
      target_r <= target_s;
    end
  end

  assign song_addr = addr_r;
  assign led       = led_r;
  assign pitch_led = pled_r;
  assign hits      = hits_r;
  assign misses    = misses_r;
  assign done      = done_r;

endmodule
